busca_decodifica: RTL and testbench

- Instruction fetch and decode stage. It sits directly upstream of the multi-cycle control unit.
- On a fetch request it reads one 32-bit instruction from instruction memory at the current PC, using a req/ack handshake, and latches it into an instruction register (IR).
- From the IR it presents the decoded fields (opcode, funct7, funct3, register indices) and the sign-extended 64-bit immediates consumed by the control unit and the PC adder.

---
 rtl/busca_decodifica.sv | 167 ++++++++++++++++
 tb/tb_busca_decodifica.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/busca_decodifica.sv
// Instruction fetch/decode stage: fetches one 32-bit word over a req/ack
// handshake into the IR and decodes fields and sign-extended immediates.
module busca_decodifica #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            busca,
  input  logic [XLEN-1:0] pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_data,
  output logic            pronto,
  output logic            instr_valid,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] imm_pc,
  output logic            ilegal,
  output logic            erro_alinhamento,
  output logic            erro_timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic {OCIOSO, ESPERA} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       ir_reg, ir_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [XLEN-1:0]   addr_reg, addr_next;
  logic              req_reg, req_next;
  logic              pronto_reg, pronto_next;
  logic              valid_reg, valid_next;
  logic              align_reg, align_next;
  logic              tout_reg, tout_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= OCIOSO;
      ir_reg     <= '0;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      req_reg    <= 1'b0;
      pronto_reg <= 1'b0;
      valid_reg  <= 1'b0;
      align_reg  <= 1'b0;
      tout_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ir_reg     <= ir_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      req_reg    <= req_next;
      pronto_reg <= pronto_next;
      valid_reg  <= valid_next;
      align_reg  <= align_next;
      tout_reg   <= tout_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ir_next     = ir_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    req_next    = req_reg;
    pronto_next = 1'b0;
    valid_next  = valid_reg;
    align_next  = align_reg;
    tout_next   = tout_reg;
    case (state_reg)
      OCIOSO: begin
        if (busca) begin
          if (pc[1:0] == 2'b00) begin
            addr_next  = pc;
            req_next   = 1'b1;
            valid_next = 1'b0;
            cnt_next   = '0;
            state_next = ESPERA;
          end else begin
            align_next = 1'b1;
          end
        end
      end
      ESPERA: begin
        // An ack on the last allowed cycle still counts as a normal latch.
        if (mem_ack) begin
          ir_next     = mem_data;
          valid_next  = 1'b1;
          pronto_next = 1'b1;
          req_next    = 1'b0;
          state_next  = OCIOSO;
        end else if (cnt_reg == CNT_LAST) begin
          req_next   = 1'b0;
          tout_next  = 1'b1;
          state_next = OCIOSO;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = OCIOSO;
    endcase
  end

  assign mem_req          = req_reg;
  assign mem_addr         = addr_reg;
  assign pronto           = pronto_reg;
  assign instr_valid      = valid_reg;
  assign erro_alinhamento = align_reg;
  assign erro_timeout     = tout_reg;

  assign opcode = ir_reg[6:0];
  assign funct3 = ir_reg[14:12];
  assign funct7 = ir_reg[31:25];
  assign rs1    = ir_reg[19:15];
  assign rs2    = ir_reg[24:20];
  assign rd     = ir_reg[11:7];

  logic op_known;

  always_comb begin
    imm      = '0;
    imm_pc   = '0;
    op_known = 1'b1;
    case (ir_reg[6:0])
      OP_LOAD, OP_IMM, OP_JALR:
        imm = {{(XLEN-12){ir_reg[31]}}, ir_reg[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
      OP_BR: begin
        imm    = {{(XLEN-13){ir_reg[31]}}, ir_reg[31], ir_reg[7],
                  ir_reg[30:25], ir_reg[11:8], 1'b0};
        imm_pc = imm;
      end
      OP_LUI, OP_AUIPC:
        imm = {{(XLEN-32){ir_reg[31]}}, ir_reg[31:12], 12'b0};
      OP_JAL: begin
        imm    = {{(XLEN-21){ir_reg[31]}}, ir_reg[31], ir_reg[19:12],
                  ir_reg[20], ir_reg[30:21], 1'b0};
        imm_pc = imm;
      end
      OP_R:    op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  assign ilegal = valid_reg & ~op_known;

endmodule

// File: tb/tb_busca_decodifica.sv
// Randomized and directed bench for busca_decodifica against a transaction-level
// reference model of fetch outcomes and instruction decoding.
module tb_busca_decodifica;
  localparam int XLEN = 64;
  localparam int TOUT = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            busca;
  logic [XLEN-1:0] pc;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [31:0]     mem_data;
  logic            pronto, instr_valid, ilegal, erro_alinhamento, erro_timeout;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm, imm_pc;

  busca_decodifica #(.XLEN(XLEN), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .busca(busca), .pc(pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .pronto(pronto), .instr_valid(instr_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .imm_pc(imm_pc),
    .ilegal(ilegal), .erro_alinhamento(erro_alinhamento), .erro_timeout(erro_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: what the stage should hold after each transaction.
  logic [31:0]     m_ir;
  logic            m_valid, m_align, m_tout;
  logic [XLEN-1:0] m_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int n);
    longint x;
    x = longint'(v) <<< (64 - n);
    return 64'(x >>> (64 - n));
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: return sext(64'(w[31:20]), 12);
      7'b0100011: return sext(64'({w[31:25], w[11:7]}), 12);
      7'b1100011: return sext(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      7'b0110111, 7'b0010111: return sext(64'({w[31:12], 12'b0}), 32);
      7'b1101111: return sext(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b1100011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  endfunction

  task automatic check_state(input string tag);
    logic [63:0] e_imm;
    e_imm = ref_imm(m_ir);
    chk({tag, ".instr_valid"}, 64'(instr_valid), 64'(m_valid));
    chk({tag, ".mem_addr"}, mem_addr, m_addr);
    chk({tag, ".erro_alin"}, 64'(erro_alinhamento), 64'(m_align));
    chk({tag, ".erro_tout"}, 64'(erro_timeout), 64'(m_tout));
    chk({tag, ".opcode"}, 64'(opcode), 64'(m_ir[6:0]));
    chk({tag, ".funct3"}, 64'(funct3), 64'(m_ir[14:12]));
    chk({tag, ".funct7"}, 64'(funct7), 64'(m_ir[31:25]));
    chk({tag, ".rs1"}, 64'(rs1), 64'(m_ir[19:15]));
    chk({tag, ".rs2"}, 64'(rs2), 64'(m_ir[24:20]));
    chk({tag, ".rd"}, 64'(rd), 64'(m_ir[11:7]));
    chk({tag, ".imm"}, imm, e_imm);
    chk({tag, ".imm_pc"}, imm_pc,
        (m_ir[6:0] == 7'b1100011 || m_ir[6:0] == 7'b1101111) ? e_imm : 64'd0);
    chk({tag, ".ilegal"}, 64'(ilegal), 64'(m_valid && !is_legal(m_ir[6:0])));
  endtask

  // One busca pulse; memory answers 'delay' cycles after the request rises
  // (delay beyond the timeout window models a late or missing ack).
  task automatic fetch(input string tag, input logic [XLEN-1:0] p, input logic [31:0] data,
                       input int delay, input bit inject);
    int req_cyc = 0;
    int pr_cyc  = 0;
    int exp_req = 0;
    int exp_pr  = 0;
    bit inj;
    inj = inject && (p[1:0] == 2'b00) && (delay != 1);
    @(negedge clk);
    busca = 1'b1;
    pc    = p;
    @(negedge clk);
    busca = 1'b0;
    for (int i = 1; i <= TOUT + 6; i++) begin
      if (mem_req) req_cyc++;
      if (pronto)  pr_cyc++;
      mem_ack  = (i == delay);
      mem_data = (i == delay) ? data : $urandom;
      busca    = inj && (i == 2);
      pc       = inj ? p + 64'd8 : p;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    busca   = 1'b0;
    if (p[1:0] != 2'b00) begin
      m_align = 1'b1;
    end else begin
      m_addr = p;
      if (delay >= 1 && delay <= TOUT) begin
        exp_req = delay;
        exp_pr  = 1;
        m_ir    = data;
        m_valid = 1'b1;
      end else begin
        exp_req = TOUT;
        m_valid = 1'b0;
        m_tout  = 1'b1;
      end
    end
    chk({tag, ".req_cycles"}, 64'(req_cyc), 64'(exp_req));
    chk({tag, ".pronto_pulses"}, 64'(pr_cyc), 64'(exp_pr));
    check_state(tag);
    $display("txn %s pc=%h data=%h delay=%0d req=%0d pronto=%0d valid=%0b", tag, p, data,
             delay, req_cyc, pr_cyc, instr_valid);
  endtask

  task automatic model_reset();
    m_ir = '0; m_valid = 1'b0; m_align = 1'b0; m_tout = 1'b0; m_addr = '0;
  endtask

  logic [6:0] ops [10];
  logic [31:0] w;
  logic [XLEN-1:0] rp;

  initial begin
    ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};
    reset = 1'b0; busca = 1'b0; pc = '0; mem_ack = 1'b0; mem_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset.mem_req", 64'(mem_req), 64'd0);
    chk("reset.pronto", 64'(pronto), 64'd0);
    check_state("reset");
    reset = 1'b1;

    fetch("add", 64'h40, 32'h00A30333, 3, 1'b0);
    chk("add.rd_const", 64'(rd), 64'd6);
    chk("add.rs2_const", 64'(rs2), 64'd10);
    fetch("ld", 64'h44, 32'hFFC0B083, 1, 1'b0);
    chk("ld.imm_const", imm, 64'hFFFFFFFFFFFFFFFC);
    fetch("beq", 64'h48, 32'hFE000EE3, 5, 1'b1);
    fetch("lui", 64'h4C, 32'h123450B7, 2, 1'b0);
    chk("lui.imm_const", imm, 64'h0000000012345000);
    fetch("ack_last", 64'h50, 32'h00C58533, TOUT, 1'b0);
    fetch("illegal", 64'h54, 32'h0000007F, 4, 1'b0);
    fetch("misalign", 64'h42, 32'h00000013, 3, 1'b0);
    fetch("timeout_late_ack", 64'h58, 32'h00100093, TOUT + 4, 1'b1);

    // Reset in the middle of a pending request, then a stray ack.
    @(negedge clk); busca = 1'b1; pc = 64'h100;
    @(negedge clk); busca = 1'b0;
    @(negedge clk);
    chk("midreset.req_before", 64'(mem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("midreset.req_async", 64'(mem_req), 64'd0);
    check_state("midreset");
    @(negedge clk); reset = 1'b1; mem_ack = 1'b1; mem_data = 32'h00A30333;
    @(negedge clk); mem_ack = 1'b0;
    chk("stray_ack.pronto", 64'(pronto), 64'd0);
    chk("stray_ack.req", 64'(mem_req), 64'd0);
    check_state("stray_ack");
    $display("txn midreset stray ack ignored valid=%0b", instr_valid);

    for (int k = 0; k < 40; k++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 9)];
      rp = {32'd0, $urandom} & 64'h0000_0000_000F_FFFC;
      if ($urandom_range(0, 7) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      fetch($sformatf("rnd%0d", k), rp, w, $urandom_range(1, TOUT + 4),
            1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
